adder_share_arbiter: RTL and testbench

- Shares one `fast_adder` instance among REQ_NUM requesters.
- Round-robin grant, registered result with valid/ready output handshake, one add issued per cycle at most.
- Sits between ALU-side requesters (address gen, counter reload, ALU) and the single carry-lookahead adder, so the design carries only one wide adder.

---
 rtl/adder_share_arbiter.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_adder_share_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one carry-lookahead fast_adder among REQ_NUM requesters.
// Optional multi-word carry chaining is enabled with `define ADDER_SHARE_CHAIN_EN.

module fast_adder_cla #(
    parameter int bit_width    = 16,
    parameter int cascade_size = 4
) (
    input  logic [bit_width-1:0] A,
    input  logic [bit_width-1:0] B,
    input  logic                 C_IN,
    output logic [bit_width-1:0] R,
    output logic                 P,
    output logic                 G
);
    localparam int SUB = bit_width / cascade_size;

    logic [cascade_size-1:0] p_s;
    logic [cascade_size-1:0] g_s;
    logic [cascade_size-1:0] c;

    generate
        if (bit_width == cascade_size) begin : g_leaf
            assign p_s = A ^ B;
            assign g_s = A & B;
            assign R   = p_s ^ c;
        end else begin : g_node
            for (genvar i = 0; i < cascade_size; i++) begin : g_sub
                fast_adder_cla #(
                    .bit_width   (SUB),
                    .cascade_size(cascade_size)
                ) u_sub (
                    .A   (A[i*SUB +: SUB]),
                    .B   (B[i*SUB +: SUB]),
                    .C_IN(c[i]),
                    .R   (R[i*SUB +: SUB]),
                    .P   (p_s[i]),
                    .G   (g_s[i])
                );
            end
        end
    endgenerate

    // Every block carry is a flat sum-of-products of the group P/G terms.
    always_comb begin
        logic carry;
        logic prop;
        carry = 1'b0;
        prop  = 1'b1;
        c     = '0;
        c[0]  = C_IN;
        for (int i = 0; i < cascade_size - 1; i++) begin
            carry = 1'b0;
            prop  = 1'b1;
            for (int j = i; j >= 0; j--) begin
                carry = carry | (prop & g_s[j]);
                prop  = prop & p_s[j];
            end
            c[i+1] = carry | (prop & C_IN);
        end
        carry = 1'b0;
        prop  = 1'b1;
        for (int j = cascade_size - 1; j >= 0; j--) begin
            carry = carry | (prop & g_s[j]);
            prop  = prop & p_s[j];
        end
        G = carry;
        P = prop;
    end
endmodule

module fast_adder #(
    parameter int bit_width    = 16,
    parameter int cascade_size = 4
) (
    input  logic [bit_width-1:0] A,
    input  logic [bit_width-1:0] B,
    input  logic                 C_IN,
    output logic [bit_width-1:0] R,
    output logic                 C_OUT,
    output logic                 P,
    output logic                 G
);
    fast_adder_cla #(
        .bit_width   (bit_width),
        .cascade_size(cascade_size)
    ) u_cla (
        .A   (A),
        .B   (B),
        .C_IN(C_IN),
        .R   (R),
        .P   (P),
        .G   (G)
    );

    assign C_OUT = G | (P & C_IN);
endmodule

module adder_share_arbiter #(
    parameter  int REQ_NUM      = 4,
    parameter  int bit_width    = 16,
    parameter  int cascade_size = 4,
    localparam int ID_W         = $clog2(REQ_NUM)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [REQ_NUM-1:0]           req_valid,
    output logic [REQ_NUM-1:0]           req_ready,
    input  logic [REQ_NUM*bit_width-1:0] req_a,
    input  logic [REQ_NUM*bit_width-1:0] req_b,
    input  logic [REQ_NUM-1:0]           req_cin,
`ifdef ADDER_SHARE_CHAIN_EN
    input  logic [REQ_NUM-1:0]           req_chain,
`endif
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [ID_W-1:0]              rsp_id,
    output logic [bit_width-1:0]         rsp_r,
    output logic                         rsp_cout,
    output logic                         rsp_p,
    output logic                         rsp_g
);
    // Handshake: a request transfers on an edge where req_valid[i] & req_ready[i];
    // a result leaves on an edge where rsp_valid & rsp_ready.
    logic                 rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
    logic [bit_width-1:0] rsp_r_q, rsp_r_d;
    logic                 rsp_cout_q, rsp_cout_d;
    logic                 rsp_p_q, rsp_p_d;
    logic                 rsp_g_q, rsp_g_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;

    logic                 can_issue;
    logic                 grant_any;
    logic [ID_W-1:0]      grant_idx;
    logic                 lock_active;
    logic [ID_W-1:0]      lock_idx;
    logic                 lock_carry;

    logic [bit_width-1:0] add_a, add_b, add_r;
    logic                 add_cin, add_cout, add_p, add_g;

`ifdef ADDER_SHARE_CHAIN_EN
    logic                 lock_valid_q, lock_valid_d;
    logic [ID_W-1:0]      lock_id_q, lock_id_d;
    logic                 carry_hold_q, carry_hold_d;

    assign lock_active = lock_valid_q;
    assign lock_idx    = lock_id_q;
    assign lock_carry  = carry_hold_q;
`else
    assign lock_active = 1'b0;
    assign lock_idx    = '0;
    assign lock_carry  = 1'b0;
`endif

    // Depends only on registered rsp_valid, never on the edge that may clear it.
    assign can_issue = ~rsp_valid_q | rsp_ready;

    always_comb begin
        int idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        if (can_issue) begin
            if (lock_active) begin
                grant_any = req_valid[lock_idx];
                grant_idx = lock_idx;
            end else begin
                // Scan farthest-first so the nearest requester after rr_ptr wins.
                for (int k = REQ_NUM; k >= 1; k--) begin
                    idx = (int'(rr_ptr_q) + k) % REQ_NUM;
                    if (req_valid[idx]) begin
                        grant_any = 1'b1;
                        grant_idx = ID_W'(idx);
                    end
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (grant_any) begin
            add_a   = req_a[int'(grant_idx)*bit_width +: bit_width];
            add_b   = req_b[int'(grant_idx)*bit_width +: bit_width];
            add_cin = lock_active ? lock_carry : req_cin[grant_idx];
        end
    end

    fast_adder #(
        .bit_width   (bit_width),
        .cascade_size(cascade_size)
    ) u_fast_adder (
        .A    (add_a),
        .B    (add_b),
        .C_IN (add_cin),
        .R    (add_r),
        .C_OUT(add_cout),
        .P    (add_p),
        .G    (add_g)
    );

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_r_d     = rsp_r_q;
        rsp_cout_d  = rsp_cout_q;
        rsp_p_d     = rsp_p_q;
        rsp_g_d     = rsp_g_q;
        rr_ptr_d    = rr_ptr_q;
`ifdef ADDER_SHARE_CHAIN_EN
        lock_valid_d = lock_valid_q;
        lock_id_d    = lock_id_q;
        carry_hold_d = carry_hold_q;
`endif
        if (grant_any) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = grant_idx;
            rsp_r_d     = add_r;
            rsp_cout_d  = add_cout;
            rsp_p_d     = add_p;
            rsp_g_d     = add_g;
            if (!lock_active) begin
                rr_ptr_d = grant_idx;
            end
`ifdef ADDER_SHARE_CHAIN_EN
            if (req_chain[grant_idx]) begin
                lock_valid_d = 1'b1;
                lock_id_d    = grant_idx;
                carry_hold_d = add_cout;
            end else begin
                lock_valid_d = 1'b0;
            end
`endif
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_r_q     <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_p_q     <= 1'b0;
            rsp_g_q     <= 1'b0;
            rr_ptr_q    <= ID_W'(REQ_NUM - 1);
`ifdef ADDER_SHARE_CHAIN_EN
            lock_valid_q <= 1'b0;
            lock_id_q    <= '0;
            carry_hold_q <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_r_q     <= rsp_r_d;
            rsp_cout_q  <= rsp_cout_d;
            rsp_p_q     <= rsp_p_d;
            rsp_g_q     <= rsp_g_d;
            rr_ptr_q    <= rr_ptr_d;
`ifdef ADDER_SHARE_CHAIN_EN
            lock_valid_q <= lock_valid_d;
            lock_id_q    <= lock_id_d;
            carry_hold_q <= carry_hold_d;
`endif
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_r     = rsp_r_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_p     = rsp_p_q;
    assign rsp_g     = rsp_g_q;
endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter: directed cases plus randomized traffic against a behavioural model.
// Chain cases are included when ADDER_SHARE_CHAIN_EN is defined.

module tb_adder_share_arbiter;
    localparam int N = 4;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_cin;
`ifdef ADDER_SHARE_CHAIN_EN
    logic [N-1:0]   req_chain;
`endif
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_r;
    logic           rsp_cout;
    logic           rsp_p;
    logic           rsp_g;

    adder_share_arbiter #(.REQ_NUM(N), .bit_width(W), .cascade_size(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_cin  (req_cin),
`ifdef ADDER_SHARE_CHAIN_EN
        .req_chain(req_chain),
`endif
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .rsp_r    (rsp_r),
        .rsp_cout (rsp_cout),
        .rsp_p    (rsp_p),
        .rsp_g    (rsp_g)
    );

    always #5 clk = ~clk;

    // Expected result record: {id, cout, p, g, r}
    logic [20:0] exp_q[$];
    logic [20:0] held;
    int          last_grant;
    int          prev_g;
    bit          lock_m;
    int          lock_id_m;
    bit          hold_m;
    int          total = 0;
    int          bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int model_grant();
        if (exp_q.size() != 0 && !rsp_ready) return -1;
        if (lock_m) return req_valid[lock_id_m] ? lock_id_m : -1;
        for (int k = 1; k <= N; k++) begin
            if (req_valid[(last_grant + k) % N]) return (last_grant + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        held       = '0;
        last_grant = N - 1;
        lock_m     = 1'b0;
        lock_id_m  = 0;
        hold_m     = 1'b0;
    endtask

    // Checks outputs at negedge, advances the model, returns 1ns after the posedge.
    task automatic cycle();
        int          g;
        logic [3:0]  exp_rdy;
        logic [15:0] a, b;
        logic        cin_eff;
        logic [16:0] s, s0;
        logic [20:0] exp_out;
        @(negedge clk);
        g       = model_grant();
        exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0;
        exp_out = (exp_q.size() != 0) ? exp_q[0] : held;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("rsp_valid", 32'(rsp_valid), 32'(exp_q.size() != 0));
        check("rsp_data", 32'({rsp_id, rsp_cout, rsp_p, rsp_g, rsp_r}), 32'(exp_out));
        prev_g = g;
        if (reset) begin
            model_reset();
        end else begin
            if (exp_q.size() != 0 && rsp_ready) held = exp_q.pop_front();
            if (g >= 0) begin
                a       = req_a[g*W +: W];
                b       = req_b[g*W +: W];
                cin_eff = lock_m ? hold_m : req_cin[g];
                s       = {1'b0, a} + {1'b0, b} + 17'(cin_eff);
                s0      = {1'b0, a} + {1'b0, b};
                exp_q.push_back({2'(g), s[16], &(a ^ b), s0[16], s[15:0]});
                if (!lock_m) last_grant = g;
`ifdef ADDER_SHARE_CHAIN_EN
                if (req_chain[g]) begin
                    lock_m    = 1'b1;
                    lock_id_m = g;
                    hold_m    = s[16];
                end else begin
                    lock_m = 1'b0;
                end
`endif
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b, input logic cin);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_cin[i]      = cin;
    endtask

    initial begin
        logic [15:0] r_save;
        logic [3:0]  seq_id [5];
        seq_id = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
        reset     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        rsp_ready = 1'b1;
        prev_g    = -1;
`ifdef ADDER_SHARE_CHAIN_EN
        req_chain = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check("reset_valid", 32'(rsp_valid), 32'd0);
        check("reset_data", 32'({rsp_id, rsp_cout, rsp_p, rsp_g, rsp_r}), 32'd0);
        reset = 1'b0;

        // Single request from requester 0
        req_valid = 4'b0001;
        set_req(0, 16'h1234, 16'h0F0F, 1'b0);
        #1 check("t1_ready", 32'(req_ready), 32'h1);
        cycle();
        check("t1_r", 32'(rsp_r), 32'h2143);
        check("t1_id_cout", 32'({rsp_valid, rsp_id, rsp_cout}), 32'({1'b1, 2'd0, 1'b0}));

        // Round-robin over all four with a fresh start
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        req_valid = 4'b1111;
        for (int i = 0; i < N; i++) set_req(i, 16'(i * 16'h0101), 16'h0011, 1'b0);
        for (int k = 0; k < 5; k++) begin
            #1 check("rr_ready", 32'(req_ready), 32'(1 << seq_id[k]));
            cycle();
            check("rr_id", 32'(rsp_id), 32'(seq_id[k]));
        end

        // Overflow boundaries from requester 0 (last grant was 0, so 1 is next)
        req_valid = 4'b0001;
        set_req(0, 16'hFFFF, 16'h0001, 1'b0);
        cycle();
        check("ovf1", 32'({rsp_cout, rsp_r}), 32'h10000);
        set_req(0, 16'hFFFF, 16'h0000, 1'b1);
        cycle();
        check("ovf2", 32'({rsp_cout, rsp_p, rsp_r}), 32'h30000);

        // Stall with result held
        rsp_ready = 1'b0;
        req_valid = 4'b0110;
        set_req(1, 16'h0100, 16'h0023, 1'b0);
        set_req(2, 16'h0200, 16'h0045, 1'b0);
        r_save = rsp_r;
        for (int k = 0; k < 3; k++) begin
            #1 check("stall_ready", 32'(req_ready), 32'h0);
            cycle();
            check("stall_hold", 32'({rsp_valid, rsp_r}), 32'({1'b1, r_save}));
        end
        rsp_ready = 1'b1;
        #1 check("drain_ready", 32'(req_ready), 32'h2);
        cycle();
        check("drain_issue", 32'({rsp_valid, rsp_id, rsp_r}), 32'({1'b1, 2'd1, 16'h0123}));

        // Reset with a result in flight
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        reset     = 1'b1;
        cycle();
        reset = 1'b0;
        check("rst_flush", 32'(rsp_valid), 32'h0);
        #1 check("rst_first", 32'(req_ready), 32'h1);
        cycle();
        rsp_ready = 1'b1;
        cycle();

`ifdef ADDER_SHARE_CHAIN_EN
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        req_valid = 4'b0010;
        cycle();
        req_valid = 4'b0101;
        set_req(0, 16'h0007, 16'h0008, 1'b0);
        set_req(2, 16'hFFFF, 16'h0001, 1'b0);
        req_chain = 4'b0100;
        #1 check("chain_g1", 32'(req_ready), 32'h4);
        cycle();
        check("chain_w1", 32'({rsp_cout, rsp_r}), 32'h10000);
        set_req(2, 16'h0000, 16'h0000, 1'b0);
        req_chain = 4'b0000;
        #1 check("chain_g2", 32'(req_ready), 32'h4);
        cycle();
        check("chain_w2", 32'({rsp_id, rsp_r}), 32'({2'd2, 16'h0001}));
        req_valid = 4'b0001;
        #1 check("chain_after", 32'(req_ready), 32'h1);
        cycle();
`endif

        // Randomized traffic; ungranted valid requesters keep their operands
        for (int n = 0; n < 400; n++) begin
            logic [N-1:0] pending;
            for (int i = 0; i < N; i++) pending[i] = req_valid[i] && (prev_g != i) && !reset;
            reset     = ($urandom_range(0, 49) == 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!pending[i]) begin
                    set_req(i,
                            ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom),
                            ($urandom_range(0, 3) == 0) ? 16'h0001 : 16'($urandom),
                            1'($urandom));
                    req_valid[i] = 1'($urandom);
`ifdef ADDER_SHARE_CHAIN_EN
                    req_chain[i] = ($urandom_range(0, 3) == 0);
`endif
                end
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
